// File: rtl/fb_pkg.sv
// Shared constants and types for the frame buffer write path.
// Default resolution, address width, palette indices and the arbiter state encoding.
package fb_pkg;

  localparam int FB_H_RES  = 640;
  localparam int FB_V_RES  = 360;
  localparam int FB_ADDR_W = $clog2(FB_H_RES * FB_V_RES);

  typedef logic [3:0] color_t;

  typedef enum logic {
    ARB,
    CLEAR
  } fb_arb_state_t;

  localparam color_t BLACK  = 4'd0;
  localparam color_t WHITE  = 4'd1;
  localparam color_t RED    = 4'd2;
  localparam color_t GREEN  = 4'd3;
  localparam color_t BLUE   = 4'd4;
  localparam color_t YELLOW = 4'd5;

endpackage

// File: rtl/fb_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the requester not granted last wins a tie.
// last_grant_q holds the index of the most recent transfer and moves only when a grant is issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
      // A grant is always a transfer, since it is only raised on a valid requester.
      if (grant != 2'b00) last_grant_d = grant[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame buffer write port arbiter: two round-robin brushes plus a full-buffer clear sweep.
// Optional FB_ARB_STATS_EN adds saturating per-brush grant counters and an out-of-range drop counter.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int H_RES  = FB_H_RES,
  parameter int V_RES  = FB_V_RES,
  parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic [1:0]        req_valid_in,
  output logic [1:0]        req_ready_out,
  input  logic [1:0][9:0]   x_in,
  input  logic [1:0][8:0]   y_in,
  input  color_t [1:0]      color_in,
  input  logic              clear_req_in,
  input  color_t            clear_color_in,
  output logic              busy_out,
  output logic              clear_done_out,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output color_t            wr_data_out
`ifdef FB_ARB_STATS_EN
  ,
  output logic [1:0][15:0]  grant_cnt_out,
  output logic [15:0]       drop_cnt_out
`endif
);

  localparam logic [31:0]       H_RES_U   = 32'(H_RES);
  localparam logic [31:0]       V_RES_U   = 32'(V_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  fb_arb_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  color_t            clear_color_q, clear_color_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  color_t            wr_data_q, wr_data_d;
  logic              done_q, done_d;

  logic              arb_en;
  logic [1:0]        grant;
  logic              sel;
  logic              transfer;
  logic              in_range;
  logic [ADDR_W-1:0] brush_addr;

  // Clear has priority in the very cycle it is requested, so brushes see ready low immediately.
  assign arb_en   = (state_q == ARB) && !clear_req_in;
  assign sel      = grant[1];
  assign transfer = |grant;
  assign in_range = (32'(x_in[sel]) < H_RES_U) && (32'(y_in[sel]) < V_RES_U);
  assign brush_addr = ADDR_W'(32'(x_in[sel]) + H_RES_U * 32'(y_in[sel]));

  rr_arbiter2 u_rr (
    .clk    (pixel_clk_in),
    .rst_n  (rst_n_in),
    .enable (arb_en),
    .req    (req_valid_in),
    .grant  (grant)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clear_color_d = clear_color_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    done_d        = 1'b0;
    case (state_q)
      ARB: begin
        if (clear_req_in) begin
          state_d       = CLEAR;
          cnt_d         = '0;
          clear_color_d = clear_color_in;
        end else if (transfer && in_range) begin
          wr_en_d   = 1'b1;
          wr_addr_d = brush_addr;
          wr_data_d = color_in[sel];
        end
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = clear_color_q;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ARB;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ARB;
      cnt_q         <= '0;
      clear_color_q <= BLACK;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= BLACK;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clear_color_q <= clear_color_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      done_q        <= done_d;
    end
  end

  assign req_ready_out  = grant;
  assign busy_out       = (state_q == CLEAR);
  assign clear_done_out = done_q;
  assign wr_en_out      = wr_en_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;

`ifdef FB_ARB_STATS_EN
  logic [1:0][15:0] grant_cnt_q, grant_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  // Counters saturate rather than wrap; a clear start begins a fresh frame of statistics.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (state_q == ARB && clear_req_in) begin
      grant_cnt_d = '0;
      drop_cnt_d  = '0;
    end else if (transfer) begin
      if (in_range) begin
        if (grant_cnt_q[sel] != 16'hFFFF) grant_cnt_d[sel] = grant_cnt_q[sel] + 16'd1;
      end else begin
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      grant_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign grant_cnt_out = grant_cnt_q;
  assign drop_cnt_out  = drop_cnt_q;
`endif

endmodule
